sys_serial_launcher: RTL and testbench

SYS_SERIAL_LAUNCHER -- requirements
Module: sys_serial_launcher

---
 rtl/sys_serial_launcher.sv | 216 +++++++++++++++++++++
 tb/tb_sys_serial_launcher.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_serial_launcher.sv
// Purpose : assemble a serial frame of A/B operands plus an iteration count, then launch a PE array
//           with a start pulse followed by staggered or broadcast per-lane write-enables.
// Latency : ready one cycle after the last frame bit; start one cycle after load_go acceptance;
//           enables from the following cycle.
// Backpr. : no stall path; ser_valid bits arriving while a frame is held or a launch runs are dropped
//           and flagged on the sticky overrun output.
//
// Ports   : clk, rst_n (async, active-low)
//           ser_in/ser_valid : serial frame bit stream, first bit lands in the count-field MSB
//           mode             : 0 staggered enables, 1 broadcast enables (sampled with load_go)
//           load_go          : launch request, honoured only while ready=1
//           a_lane/b_lane/max_cntr : operands and count held from the last accepted launch
//           start/awe/bwe/done     : launch pulses; ready/busy/overrun : status
module sys_serial_launcher #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int DW   = 16,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_in,
    input  logic                 ser_valid,
    input  logic                 mode,
    input  logic                 load_go,
    output logic [ROWS*DW-1:0]   a_lane,
    output logic [COLS*DW-1:0]   b_lane,
    output logic [CW-1:0]        max_cntr,
    output logic                 start,
    output logic [ROWS-1:0]      awe,
    output logic [COLS-1:0]      bwe,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int FL  = (ROWS + COLS) * DW + CW;
    localparam int BCW = $clog2(FL + 1);
    localparam int S   = ROWS + COLS;
    localparam int SW  = $clog2(S + 1);
    localparam int M   = (ROWS < COLS) ? ROWS : COLS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        LAUNCH  = 2'd2,
        STAGGER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FL-1:0]       chain_q, chain_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic                mode_q, mode_d;
    logic [ROWS*DW-1:0]  a_lane_q, a_lane_d;
    logic [COLS*DW-1:0]  b_lane_q, b_lane_d;
    logic [CW-1:0]       max_cntr_q, max_cntr_d;
    logic                start_q, start_d;
    logic [ROWS-1:0]     awe_q, awe_d;
    logic [COLS-1:0]     bwe_q, bwe_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [SW-1:0]       last_slot;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        chain_d    = chain_q;
        slot_d     = slot_q;
        mode_d     = mode_q;
        a_lane_d   = a_lane_q;
        b_lane_d   = b_lane_q;
        max_cntr_d = max_cntr_q;
        overrun_d  = overrun_q;
        start_d    = 1'b0;
        awe_d      = '0;
        bwe_d      = '0;
        done_d     = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;

        // Broadcast launches occupy a single enable slot.
        last_slot = mode_q ? '0 : SW'(S - 1);

        case (state_q)
            IDLE: begin
                if (ser_valid) begin
                    // One flat left shift: chain bit 0 is A lane 0 LSB, the top CW bits are the count.
                    chain_d   = {chain_q[FL-2:0], ser_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(FL - 1)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (load_go) begin
                    a_lane_d   = chain_q[ROWS*DW-1:0];
                    b_lane_d   = chain_q[(ROWS+COLS)*DW-1:ROWS*DW];
                    max_cntr_d = chain_q[FL-1:(ROWS+COLS)*DW];
                    mode_d     = mode;
                    overrun_d  = 1'b0;
                    state_d    = LAUNCH;
                end
                // A bit dropped in the accepting cycle still counts as an overrun.
                if (ser_valid) begin
                    overrun_d = 1'b1;
                end
            end
            LAUNCH: begin
                if (ser_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = STAGGER;
                slot_d  = '0;
            end
            STAGGER: begin
                if (ser_valid) begin
                    overrun_d = 1'b1;
                end
                if (slot_q == last_slot) begin
                    state_d   = IDLE;
                    slot_d    = '0;
                    bit_cnt_d = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status and pulse outputs are registered images of the next state, so they line up
        // with the state they describe.
        ready_d = (state_d == READY);
        busy_d  = (state_d == LAUNCH) || (state_d == STAGGER);
        start_d = (state_d == LAUNCH);

        if (state_d == STAGGER) begin
            done_d = (slot_d == last_slot);
            if (mode_q) begin
                awe_d = '1;
                bwe_d = '1;
            end else begin
                // Interleave A/B for shared indices (slots 2i / 2i+1), then the longer side's
                // leftover lanes occupy slots i+M.
                for (int r = 0; r < ROWS; r++) begin
                    if (r < M) begin
                        awe_d[r] = (slot_d == SW'(2 * r));
                    end else begin
                        awe_d[r] = (slot_d == SW'(r + M));
                    end
                end
                for (int c = 0; c < COLS; c++) begin
                    if (c < M) begin
                        bwe_d[c] = (slot_d == SW'(2 * c + 1));
                    end else begin
                        bwe_d[c] = (slot_d == SW'(c + M));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            chain_q    <= '0;
            slot_q     <= '0;
            mode_q     <= 1'b0;
            a_lane_q   <= '0;
            b_lane_q   <= '0;
            max_cntr_q <= '0;
            start_q    <= 1'b0;
            awe_q      <= '0;
            bwe_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            chain_q    <= chain_d;
            slot_q     <= slot_d;
            mode_q     <= mode_d;
            a_lane_q   <= a_lane_d;
            b_lane_q   <= b_lane_d;
            max_cntr_q <= max_cntr_d;
            start_q    <= start_d;
            awe_q      <= awe_d;
            bwe_q      <= bwe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign a_lane   = a_lane_q;
    assign b_lane   = b_lane_q;
    assign max_cntr = max_cntr_q;
    assign start    = start_q;
    assign awe      = awe_q;
    assign bwe      = bwe_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sys_serial_launcher.sv
// Purpose : checks sys_serial_launcher in a 2x2 and a 3x1 configuration fed by one shared stream.
// Latency : checks sampled on the falling edge; inputs driven on the falling edge.
// Backpr. : none; both instances see identical stimulus and have the same 72-bit frame length.
module tb_sys_serial_launcher;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ser_in;
    logic        ser_valid;
    logic        mode;
    logic        load_go;

    logic [31:0] a_lane;
    logic [31:0] b_lane;
    logic [7:0]  max_cntr;
    logic        start;
    logic [1:0]  awe;
    logic [1:0]  bwe;
    logic        ready;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [47:0] a_lane2;
    logic [15:0] b_lane2;
    logic [7:0]  max_cntr2;
    logic        start2;
    logic [2:0]  awe2;
    logic [0:0]  bwe2;
    logic        ready2;
    logic        busy2;
    logic        done2;
    logic        overrun2;

    int checks = 0;
    int errors = 0;

    // Last launched values, expected to be held while frames are shifted or bits are dropped.
    logic [31:0] last_a   = '0;
    logic [31:0] last_b   = '0;
    logic [7:0]  last_cnt = '0;

    sys_serial_launcher #(.ROWS(2), .COLS(2), .DW(16), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .mode(mode),
        .load_go(load_go), .a_lane(a_lane), .b_lane(b_lane), .max_cntr(max_cntr),
        .start(start), .awe(awe), .bwe(bwe), .ready(ready), .busy(busy), .done(done),
        .overrun(overrun)
    );

    sys_serial_launcher #(.ROWS(3), .COLS(1), .DW(16), .CW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .mode(mode),
        .load_go(load_go), .a_lane(a_lane2), .b_lane(b_lane2), .max_cntr(max_cntr2),
        .start(start2), .awe(awe2), .bwe(bwe2), .ready(ready2), .busy(busy2), .done(done2),
        .overrun(overrun2)
    );

    // Frame as transmitted: count field first (MSB first), then B lanes high to low, then A lanes.
    function automatic logic [71:0] mk_frame(input logic [15:0] a0, input logic [15:0] a1,
                                             input logic [15:0] b0, input logic [15:0] b1,
                                             input logic [7:0] cnt);
        return {cnt, b1, b0, a1, a0};
    endfunction

    function automatic logic [71:0] rand_frame();
        return mk_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    endfunction

    // Sends stream bits [from, to) of frame f, first-transmitted bit being f[71].
    task automatic send_bits(input logic [71:0] f, input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            ser_in    = f[71 - i];
            ser_valid = 1'b1;
        end
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    // Requests a launch of the frame currently held and checks the whole pulse sequence of both
    // instances against a schedule built from the lane ordering rule.
    task automatic launch(input logic [71:0] f, input bit m, input bit noise);
        logic [7:0] qa[2][8];
        logic [7:0] qb[2][8];
        int         n[2];
        int         rr;
        int         cc;
        logic       exp_done;

        for (int d = 0; d < 2; d++) begin
            rr   = (d == 0) ? 2 : 3;
            cc   = (d == 0) ? 2 : 1;
            n[d] = 0;
            if (m) begin
                qa[d][0] = 8'((1 << rr) - 1);
                qb[d][0] = 8'((1 << cc) - 1);
                n[d]     = 1;
            end else begin
                for (int i = 0; i < ((rr > cc) ? rr : cc); i++) begin
                    if (i < rr) begin
                        qa[d][n[d]] = 8'(1 << i);
                        qb[d][n[d]] = 8'h00;
                        n[d]++;
                    end
                    if (i < cc) begin
                        qa[d][n[d]] = 8'h00;
                        qb[d][n[d]] = 8'(1 << i);
                        n[d]++;
                    end
                end
            end
        end

        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL launch_ready_before: ready=%b expected 1", ready);
        end
        load_go = 1'b1;
        mode    = m;

        // Cycle T: start pulse, operands copied, overrun cleared.
        @(negedge clk);
        load_go = 1'b0;
        mode    = 1'($urandom);
        checks++;
        if ({start, busy, ready, overrun, done, awe, bwe} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0}) begin
            errors++;
            $display("FAIL launch_start: start,busy,ready,overrun,done,awe,bwe=%b expected 11000_0000",
                     {start, busy, ready, overrun, done, awe, bwe});
        end
        checks++;
        if ({a_lane, b_lane, max_cntr} !== {f[31:0], f[63:32], f[71:64]}) begin
            errors++;
            $display("FAIL launch_lanes: a=%h b=%h cnt=%h expected a=%h b=%h cnt=%h",
                     a_lane, b_lane, max_cntr, f[31:0], f[63:32], f[71:64]);
        end
        checks++;
        if ({start2, a_lane2, b_lane2, max_cntr2} !== {1'b1, f[47:0], f[63:48], f[71:64]}) begin
            errors++;
            $display("FAIL launch_lanes_3x1: start=%b a=%h b=%h cnt=%h expected 1 a=%h b=%h cnt=%h",
                     start2, a_lane2, b_lane2, max_cntr2, f[47:0], f[63:48], f[71:64]);
        end
        last_a   = f[31:0];
        last_b   = f[63:32];
        last_cnt = f[71:64];
        if (noise) begin
            ser_valid = 1'b1;
            ser_in    = 1'($urandom);
            load_go   = 1'b1;
        end

        for (int k = 0; k < n[0]; k++) begin
            @(negedge clk);
            ser_valid = 1'b0;
            load_go   = noise ? 1'($urandom) : 1'b0;
            exp_done  = (k == n[0] - 1);
            checks++;
            if ({awe, bwe, done, busy, start} !== {qa[0][k][1:0], qb[0][k][1:0], exp_done, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stagger_slot%0d: awe=%b bwe=%b done=%b busy=%b start=%b expected awe=%b bwe=%b done=%b busy=1 start=0",
                         k, awe, bwe, done, busy, start, qa[0][k][1:0], qb[0][k][1:0], exp_done);
            end
            checks++;
            if ({awe2, bwe2, done2, busy2} !== {qa[1][k][2:0], qb[1][k][0], exp_done, 1'b1}) begin
                errors++;
                $display("FAIL stagger_3x1_slot%0d: awe=%b bwe=%b done=%b busy=%b expected awe=%b bwe=%b done=%b busy=1",
                         k, awe2, bwe2, done2, busy2, qa[1][k][2:0], qb[1][k][0], exp_done);
            end
        end

        @(negedge clk);
        load_go = 1'b0;
        checks++;
        if ({busy, done, start, awe, bwe, ready, overrun} !== {7'b0, 1'b0, noise}) begin
            errors++;
            $display("FAIL launch_end: busy,done,start,awe,bwe,ready,overrun=%b expected 00000000%b",
                     {busy, done, start, awe, bwe, ready, overrun}, noise);
        end
        // A load_go left over from the busy period must not trigger anything in IDLE.
        @(negedge clk);
        checks++;
        if ({start, busy, start2, busy2} !== 4'b0) begin
            errors++;
            $display("FAIL launch_idle_quiet: start,busy,start2,busy2=%b expected 0000",
                     {start, busy, start2, busy2});
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        mode      = 1'b0;
        load_go   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_lane, b_lane, max_cntr, start, awe, bwe, ready, busy, done, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {a_lane, b_lane, max_cntr, start, awe, bwe, ready, busy, done, overrun});
        end
        checks++;
        if ({a_lane2, b_lane2, max_cntr2, start2, awe2, bwe2, ready2, busy2, done2, overrun2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_3x1: got %h expected 0",
                     {a_lane2, b_lane2, max_cntr2, start2, awe2, bwe2, ready2, busy2, done2, overrun2});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed_stagger();
        logic [71:0] f;
        f = mk_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h05);
        send_bits(f, 0, 72);
        checks++;
        if ({ready, busy, a_lane} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL frame_ready: ready=%b busy=%b a=%h expected 1 0 0", ready, busy, a_lane);
        end
        launch(f, 1'b0, 1'b0);
    endtask

    task automatic test_broadcast();
        logic [71:0] f;
        f = rand_frame();
        send_bits(f, 0, 72);
        launch(f, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        logic [71:0] f;
        f = rand_frame();
        send_bits(f, 0, 72);
        send_bits(72'($urandom), 0, 5);
        checks++;
        if ({overrun, ready, busy, start} !== 4'b1100) begin
            errors++;
            $display("FAIL overrun_set: overrun,ready,busy,start=%b expected 1100",
                     {overrun, ready, busy, start});
        end
        checks++;
        if ({a_lane, b_lane, max_cntr} !== {last_a, last_b, last_cnt}) begin
            errors++;
            $display("FAIL overrun_hold: a=%h b=%h cnt=%h expected a=%h b=%h cnt=%h",
                     a_lane, b_lane, max_cntr, last_a, last_b, last_cnt);
        end
        // The dropped bits must not have disturbed the captured frame.
        launch(f, 1'($urandom), 1'b0);
    endtask

    task automatic test_random();
        logic [71:0] f;
        for (int it = 0; it < 5; it++) begin
            f = rand_frame();
            send_bits(f, 0, 72);
            launch(f, 1'($urandom), it == 4);
        end
    endtask

    task automatic test_abort();
        logic [71:0] f;
        logic [71:0] g;
        f = rand_frame();
        g = rand_frame();
        send_bits(f, 0, 40);
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
        @(negedge clk);
        checks++;
        if ({start, busy, ready} !== 3'b000) begin
            errors++;
            $display("FAIL early_load_go: start,busy,ready=%b expected 000", {start, busy, ready});
        end
        send_bits(f, 40, 60);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_lane, b_lane, max_cntr, start, awe, bwe, ready, busy, done, overrun} !== '0) begin
            errors++;
            $display("FAIL abort_reset: got %h expected 0",
                     {a_lane, b_lane, max_cntr, start, awe, bwe, ready, busy, done, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(g, 0, 71);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_71: ready=%b expected 0", ready);
        end
        send_bits(g, 71, 72);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_72: ready=%b expected 1", ready);
        end
        launch(g, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed_stagger();
        test_broadcast();
        test_overrun();
        test_random();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
